// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_arbiter
//  Purpose  : Shares the EX-stage ALU between the CPU pipeline and the crypto
//             round engine, with starvation guard and bounded lock bursts.
//  Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned LOCK_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [15:0] cpu_a,
   input  logic [15:0] cpu_b,
   input  logic [4:0]  cpu_opcode,
   input  logic [1:0]  cpu_aluop,
   output logic        cpu_stall,
   output logic        cpu_flag_we,
   input  logic        cry_req,
   input  logic        cry_lock,
   input  logic [15:0] cry_a,
   input  logic [15:0] cry_b,
   input  logic [4:0]  cry_opcode,
   input  logic [1:0]  cry_aluop,
   output logic        cry_gnt,
   output logic        cry_rvalid,
   output logic [15:0] cry_result,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [4:0]  alu_opcode,
   output logic [1:0]  alu_aluop,
   input  logic [15:0] alu_result,
   output logic        lock_active
);

   typedef enum logic [1:0] {
      CPU_OWN   = 2'd0,
      CRY_LOCK  = 2'd1,
      LOCK_HOLD = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_FULL = 4'(MAX_WAIT);
   localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

   state_t      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [7:0]  lock_cnt_q, lock_cnt_d;
   logic        cry_rvalid_q;
   logic [15:0] cry_result_q;
   logic        wait_full;

   assign wait_full = (wait_cnt_q == WAIT_FULL);

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      cry_gnt    = 1'b0;
      cpu_stall  = 1'b0;
      case (state_q)
         CRY_LOCK: begin
            // ALU stays reserved for CRY even on idle cycles of the burst
            cry_gnt   = cry_req;
            cpu_stall = cpu_req;
            if (!cry_lock) begin
               state_d = CPU_OWN;
            end else if (lock_cnt_q == LOCK_LAST) begin
               state_d = LOCK_HOLD;
            end else begin
               lock_cnt_d = lock_cnt_q + 8'd1;
            end
         end
         LOCK_HOLD: begin
            cry_gnt   = cry_req & (~cpu_req | wait_full);
            cpu_stall = cpu_req & cry_gnt;
            if (!cry_lock) begin
               state_d = CPU_OWN;
            end
         end
         default: begin
            cry_gnt   = cry_req & (~cpu_req | wait_full);
            cpu_stall = cpu_req & cry_gnt;
            if (cry_gnt && cry_lock) begin
               state_d    = CRY_LOCK;
               lock_cnt_d = 8'd1;
            end
         end
      endcase

      wait_cnt_d = 4'd0;
      if (cry_req && !cry_gnt) begin
         wait_cnt_d = wait_full ? wait_cnt_q : wait_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= CPU_OWN;
         wait_cnt_q   <= 4'd0;
         lock_cnt_q   <= 8'd0;
         cry_rvalid_q <= 1'b0;
         cry_result_q <= 16'h0000;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
         cry_rvalid_q <= cry_gnt;
         if (cry_gnt) begin
            cry_result_q <= alu_result;
         end
      end
   end

   assign cpu_flag_we = cpu_req & ~cpu_stall;
   assign alu_a       = cry_gnt ? cry_a      : cpu_a;
   assign alu_b       = cry_gnt ? cry_b      : cpu_b;
   assign alu_opcode  = cry_gnt ? cry_opcode : cpu_opcode;
   assign alu_aluop   = cry_gnt ? cry_aluop  : cpu_aluop;
   assign cry_rvalid  = cry_rvalid_q;
   assign cry_result  = cry_result_q;
   assign lock_active = (state_q == CRY_LOCK);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_share_arbiter
//  Purpose  : Directed scoreboard bench for alu_share_arbiter (MAX_WAIT=4,
//             LOCK_MAX=8); ALU stand-in is a 16-bit adder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, cry_req = 1'b0, cry_lock = 1'b0;
   logic [15:0] cpu_a = '0, cpu_b = '0, cry_a = '0, cry_b = '0;
   logic [4:0]  cpu_opcode = '0, cry_opcode = '0;
   logic [1:0]  cpu_aluop = '0, cry_aluop = '0;
   logic        cpu_stall, cpu_flag_we, cry_gnt, cry_rvalid, lock_active;
   logic [15:0] cry_result, alu_a, alu_b, alu_result;
   logic [4:0]  alu_opcode;
   logic [1:0]  alu_aluop;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic        prev_gnt = 1'b0;

   alu_share_arbiter #(.MAX_WAIT(4), .LOCK_MAX(8)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_b(cpu_b),
      .cpu_opcode(cpu_opcode), .cpu_aluop(cpu_aluop),
      .cpu_stall(cpu_stall), .cpu_flag_we(cpu_flag_we),
      .cry_req(cry_req), .cry_lock(cry_lock), .cry_a(cry_a), .cry_b(cry_b),
      .cry_opcode(cry_opcode), .cry_aluop(cry_aluop),
      .cry_gnt(cry_gnt), .cry_rvalid(cry_rvalid), .cry_result(cry_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_aluop(alu_aluop), .alu_result(alu_result),
      .lock_active(lock_active)
   );

   assign alu_result = alu_a + alu_b;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One arbitration cycle: drive at negedge, check combinational outputs just after.
   task automatic step(input logic c_req, input logic [15:0] c_a, input logic [15:0] c_b,
                       input logic y_req, input logic y_lock,
                       input logic [15:0] y_a, input logic [15:0] y_b,
                       input logic e_gnt, input logic e_stall, input logic e_lock);
      @(negedge clk);
      cpu_req = c_req;  cpu_a = c_a;  cpu_b = c_b;
      cpu_opcode = 5'h03;  cpu_aluop = 2'd1;
      cry_req = y_req;  cry_lock = y_lock;  cry_a = y_a;  cry_b = y_b;
      cry_opcode = 5'h11;  cry_aluop = 2'd2;
      #1;
      chk("cry_rvalid", {15'd0, cry_rvalid}, {15'd0, prev_gnt});
      chk("cry_gnt", {15'd0, cry_gnt}, {15'd0, e_gnt});
      chk("cpu_stall", {15'd0, cpu_stall}, {15'd0, e_stall});
      chk("cpu_flag_we", {15'd0, cpu_flag_we}, {15'd0, c_req & ~e_stall});
      chk("lock_active", {15'd0, lock_active}, {15'd0, e_lock});
      chk("alu_a", alu_a, e_gnt ? y_a : c_a);
      chk("alu_b", alu_b, e_gnt ? y_b : c_b);
      chk("alu_opcode", {11'd0, alu_opcode}, e_gnt ? 16'h0011 : 16'h0003);
      chk("alu_aluop", {14'd0, alu_aluop}, e_gnt ? 16'h0002 : 16'h0001);
      if (e_gnt) exp_q.push_back(y_a + y_b);
      prev_gnt = e_gnt;
   endtask

   // Result monitor: every cry_rvalid must match the oldest outstanding grant.
   always @(negedge clk) begin : mon
      logic [15:0] e;
      if (!rst && cry_rvalid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cry_result: rvalid with nothing pending, got %h expected none", cry_result);
         end else begin
            e = exp_q.pop_front();
            chk("cry_result", cry_result, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("rst_cry_gnt", {15'd0, cry_gnt}, 16'h0);
      chk("rst_cpu_stall", {15'd0, cpu_stall}, 16'h0);
      chk("rst_flag_we", {15'd0, cpu_flag_we}, 16'h0);
      chk("rst_lock_active", {15'd0, lock_active}, 16'h0);
      chk("rst_cry_rvalid", {15'd0, cry_rvalid}, 16'h0);
      chk("rst_cry_result", cry_result, 16'h0000);
      chk("rst_alu_a", alu_a, 16'h0000);
      chk("rst_alu_b", alu_b, 16'h0000);
      chk("rst_alu_opcode", {11'd0, alu_opcode}, 16'h0);
      chk("rst_alu_aluop", {14'd0, alu_aluop}, 16'h0);
      @(negedge clk);
      rst = 1'b0;

      // CPU alone; then cry_lock without cry_req must not lock
      repeat (3) step(1, 16'h1234, 16'h1111, 0, 0, 16'h0, 16'h0, 0, 0, 0);
      step(1, 16'h1234, 16'h1111, 0, 1, 16'h0, 16'h0, 0, 0, 0);
      step(1, 16'h1234, 16'h1111, 0, 0, 16'h0, 16'h0, 0, 0, 0);

      // CRY alone: same-cycle grant, result one cycle later, then held
      step(0, 16'h0, 16'h0, 1, 0, 16'h0303, 16'h0101, 1, 0, 0);
      step(0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
      step(0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
      chk("cry_result_hold", cry_result, 16'h0404);

      // Contention: CRY wins every 5th cycle
      for (int i = 1; i <= 10; i++)
         step(1, 16'h2222, 16'h0001, 1, 0, 16'h1000 + 16'(i), 16'h0020,
              (i % 5) == 0, (i % 5) == 0, 0);

      // Lock held 20 cycles: entry at 5, owned 5..12, hold state after, single grant at 17
      for (int i = 1; i <= 20; i++)
         step(1, 16'h3333, 16'h0001, 1, 1, 16'h4000 + 16'(i), 16'h0100,
              (i >= 5 && i <= 12) || i == 17, (i >= 5 && i <= 12) || i == 17,
              i >= 6 && i <= 12);
      step(1, 16'h3333, 16'h0001, 0, 0, 16'h0, 16'h0, 0, 0, 0);

      // Three-cycle burst, lock dropped in the third owned cycle
      for (int i = 1; i <= 4; i++)
         step(1, 16'h5555, 16'h0002, 1, 1, 16'h6000, 16'h0007, 0, 0, 0);
      step(1, 16'h5555, 16'h0002, 1, 1, 16'h6001, 16'h0010, 1, 1, 0);
      step(1, 16'h5555, 16'h0002, 1, 1, 16'h6002, 16'h0020, 1, 1, 1);
      step(1, 16'h5555, 16'h0002, 1, 0, 16'h6003, 16'h0030, 1, 1, 1);
      step(1, 16'h5555, 16'h0002, 0, 0, 16'h0, 16'h0, 0, 0, 0);
      step(0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0);

      // Reserved-but-idle lock cycle, then asynchronous reset mid-burst
      step(0, 16'h0, 16'h0, 1, 1, 16'h0A0A, 16'h0505, 1, 0, 0);
      step(0, 16'h0, 16'h0, 1, 1, 16'h0B00, 16'h0022, 1, 0, 1);
      step(1, 16'h7777, 16'h0001, 0, 1, 16'h0, 16'h0, 0, 1, 1);
      #1;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("arst_lock_active", {15'd0, lock_active}, 16'h0);
      chk("arst_cry_rvalid", {15'd0, cry_rvalid}, 16'h0);
      chk("arst_cry_result", cry_result, 16'h0000);
      chk("arst_cpu_stall", {15'd0, cpu_stall}, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      prev_gnt = 1'b0;
      step(1, 16'h7777, 16'h0001, 0, 0, 16'h0, 16'h0, 0, 0, 0);
      step(1, 16'h7777, 16'h0001, 1, 1, 16'h0C00, 16'h0001, 0, 0, 0);
      step(0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
      @(negedge clk);
      chk("pending_results", 16'(exp_q.size()), 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
